delayed_capture_arb: RTL

DELAYED_CAPTURE_ARB -- requirements
Module: delayed_capture_arb

---
 rtl/delayed_capture_pkg.sv | 9 +
 rtl/rr_arb2.sv | 15 +
 rtl/delayed_capture_arb.sv | 117 +++++++++++
 3 files changed

// File: rtl/delayed_capture_pkg.sv
// delayed_capture_pkg: shared FSM state type and default widths for delayed_capture_arb.
package delayed_capture_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DLY_W = 4;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin chooser producing a one-hot grant.
// last=1 means requester 1 won most recently, so requester 0 has priority.
module rr_arb2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt[0] = req0 & (~req1 | last);
        gnt[1] = req1 & (~req0 | ~last);
    end

endmodule

// File: rtl/delayed_capture_arb.sv
// delayed_capture_arb: arbitrates two capture requests and writes the winner's data
// into a shared register after a per-request programmable delay.
module delayed_capture_arb
    import delayed_capture_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DLY_W = DEF_DLY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [DLY_W-1:0] dly0,
    input  logic [DLY_W-1:0] dly1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] q,
    output logic             done,
    output logic             done_id,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [DLY_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             id_q, id_d;
    logic             last_q, last_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             done_q, done_d;
    logic             done_id_q, done_id_d;
    logic [1:0]       win;

    rr_arb2 u_arb (
        .req0 (req0),
        .req1 (req1),
        .last (last_q),
        .gnt  (win)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        q_d       = q_q;
        id_d      = id_q;
        last_d    = last_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        done_d    = 1'b0;
        done_id_d = 1'b0;
        case (state_q)
            // CAPTURE returns to IDLE but may accept on that same edge,
            // giving back-to-back operations dly+2 edges apart.
            IDLE, CAPTURE: begin
                state_d = IDLE;
                if (win != 2'b00) begin
                    state_d = WAIT;
                    data_d  = win[1] ? d1 : d0;
                    cnt_d   = win[1] ? dly1 : dly0;
                    id_d    = win[1];
                    last_d  = win[1];
                    gnt0_d  = win[0];
                    gnt1_d  = win[1];
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d   = CAPTURE;
                    q_d       = data_q;
                    done_d    = 1'b1;
                    done_id_d = id_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            q_q       <= '0;
            id_q      <= 1'b0;
            last_q    <= 1'b1;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            q_q       <= q_d;
            id_q      <= id_d;
            last_q    <= last_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign q       = q_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign busy    = (state_q != IDLE);

endmodule
